preproc_capture_sched: RTL and testbench

- Sequences one capture run of the preprocessing stage.
- Selects one ADC/test source, adds a signed DC offset with saturation, and slices the paced sample stream into a configured number of fixed-length packets on a ready/valid output.
- Sits between the source mux inputs and the packet/DMA side; configured from the AXI-Lite register file (SEL_SOURCE, OFFSET).

---
 rtl/preproc_capture_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_preproc_capture_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/preproc_capture_sched.sv
// preproc_capture_sched: capture-run sequencer for the preprocessing stage.
// Selects one source, adds a saturating signed offset and frames the paced
// sample stream into fixed-length packets on a one-entry ready/valid output.
// Optional macro PREPROC_RAMP_SRC_EN adds an internal ramp at source index NUM_SRC.
module preproc_capture_sched #(
    parameter int unsigned ADC_WIDTH         = 14,
    parameter int unsigned NUM_SRC           = 4,
    parameter int unsigned SEL_WIDTH         = 5,
    parameter int unsigned OFFSET_WIDTH      = 16,
    parameter int unsigned LEN_WIDTH         = 16,
    parameter int unsigned CNT_WIDTH         = 8,
    parameter int unsigned CLOCKS_PER_SAMPLE = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SEL_WIDTH-1:0]         cfg_sel_src,
    input  logic [OFFSET_WIDTH-1:0]      cfg_offset,
    input  logic [LEN_WIDTH-1:0]         cfg_pkt_len,
    input  logic [CNT_WIDTH-1:0]         cfg_pkt_num,
    input  logic                         cfg_start,
    input  logic                         cfg_abort,
    input  logic [NUM_SRC*ADC_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [ADC_WIDTH-1:0]         m_data,
    output logic                         m_valid,
    output logic                         m_last,
    input  logic                         m_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err_cfg,
    output logic                         err_overrun,
    output logic [CNT_WIDTH-1:0]         pkt_cnt
);

    localparam int unsigned SUM_WIDTH =
        ((ADC_WIDTH > OFFSET_WIDTH) ? ADC_WIDTH : OFFSET_WIDTH) + 1;
    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((2 ** (ADC_WIDTH - 1)) - 1);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StIdle, StArm, StStream, StFlush} state_t;

    state_t                  state;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic [OFFSET_WIDTH-1:0] offset_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [CNT_WIDTH-1:0]    num_q;
    logic [LEN_WIDTH-1:0]    smp_cnt;

    logic                        sel_ok;
    logic                        smp_vld;
    logic [ADC_WIDTH-1:0]        smp_raw;
    logic signed [SUM_WIDTH-1:0] sum;
    logic [ADC_WIDTH-1:0]        smp_sat;
    logic                        smp_last;
    logic                        beat_hs;
    logic [CNT_WIDTH-1:0]        pkt_inc;

`ifdef PREPROC_RAMP_SRC_EN
    localparam int unsigned DIV_WIDTH =
        (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;

    logic [DIV_WIDTH-1:0] ramp_div;
    logic [ADC_WIDTH-1:0] ramp_val;
    logic                 ramp_tick;

    assign sel_ok    = cfg_sel_src <= SEL_WIDTH'(NUM_SRC);
    assign ramp_tick = (state == StStream) &&
                       (ramp_div == DIV_WIDTH'(CLOCKS_PER_SAMPLE - 1));

    // Ramp source: restarts at 0 on ARM, one sample every CLOCKS_PER_SAMPLE cycles in STREAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_div <= '0;
            ramp_val <= '0;
        end else if (state == StArm) begin
            ramp_div <= '0;
            ramp_val <= '0;
        end else if (state == StStream) begin
            if (ramp_tick) begin
                ramp_div <= '0;
                ramp_val <= ramp_val + ADC_WIDTH'(1);
            end else begin
                ramp_div <= ramp_div + DIV_WIDTH'(1);
            end
        end
    end
`else
    assign sel_ok = cfg_sel_src < SEL_WIDTH'(NUM_SRC);
`endif

    // Source mux driven by the shadowed selection
    always_comb begin
        smp_vld = 1'b0;
        smp_raw = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (sel_q == SEL_WIDTH'(i)) begin
                smp_vld = src_valid[i];
                smp_raw = src_data[i*ADC_WIDTH +: ADC_WIDTH];
            end
        end
`ifdef PREPROC_RAMP_SRC_EN
        if (sel_q == SEL_WIDTH'(NUM_SRC)) begin
            smp_vld = ramp_tick;
            smp_raw = ramp_val;
        end
`endif
    end

    // Offset add at one bit wider than either operand, then clamp to the sample range
    always_comb begin
        sum = $signed({{(SUM_WIDTH - ADC_WIDTH){smp_raw[ADC_WIDTH-1]}}, smp_raw}) +
              $signed({{(SUM_WIDTH - OFFSET_WIDTH){offset_q[OFFSET_WIDTH-1]}}, offset_q});
        if (sum > SAT_MAX) begin
            smp_sat = SAT_MAX[ADC_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            smp_sat = SAT_MIN[ADC_WIDTH-1:0];
        end else begin
            smp_sat = sum[ADC_WIDTH-1:0];
        end
    end

    assign smp_last = (smp_cnt == len_q - LEN_WIDTH'(1));
    assign beat_hs  = m_valid & m_ready;
    assign pkt_inc  = (pkt_cnt == '1) ? pkt_cnt : pkt_cnt + CNT_WIDTH'(1);
    assign busy     = (state != StIdle);

    // Run sequencer with registered output beat, framing counters and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            sel_q       <= '0;
            offset_q    <= '0;
            len_q       <= '0;
            num_q       <= '0;
            smp_cnt     <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            done        <= 1'b0;
            err_cfg     <= 1'b0;
            err_overrun <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            done    <= 1'b0;
            err_cfg <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cfg_start) begin
                        if (sel_ok && (cfg_pkt_len != '0)) begin
                            // Shadow the validated configuration; it holds for the whole run
                            sel_q    <= cfg_sel_src;
                            offset_q <= cfg_offset;
                            len_q    <= cfg_pkt_len;
                            num_q    <= cfg_pkt_num;
                            state    <= StArm;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                StArm: begin
                    pkt_cnt     <= '0;
                    smp_cnt     <= '0;
                    err_overrun <= 1'b0;
                    m_valid     <= 1'b0;
                    m_last      <= 1'b0;
                    state       <= StStream;
                end
                StStream: begin
                    if (beat_hs && m_last && (num_q != '0) && (pkt_inc == num_q)) begin
                        // Completion takes priority over a simultaneous abort
                        pkt_cnt <= pkt_inc;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        done    <= 1'b1;
                        state   <= StIdle;
                    end else if (cfg_abort) begin
                        if (beat_hs && m_last) begin
                            pkt_cnt <= pkt_inc;
                        end
                        if (m_valid && !m_ready) begin
                            m_last <= 1'b1;
                            state  <= StFlush;
                        end else begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            state   <= StIdle;
                        end
                    end else begin
                        if (beat_hs && m_last) begin
                            pkt_cnt <= pkt_inc;
                        end
                        if (smp_vld) begin
                            if (!m_valid || m_ready) begin
                                m_data  <= smp_sat;
                                m_valid <= 1'b1;
                                m_last  <= smp_last;
                                smp_cnt <= smp_last ? '0 : smp_cnt + LEN_WIDTH'(1);
                            end else begin
                                // Output slot still occupied: drop, counter stays put
                                err_overrun <= 1'b1;
                            end
                        end else if (beat_hs) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end
                    end
                end
                StFlush: begin
                    if (m_ready) begin
                        pkt_cnt <= pkt_inc;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_preproc_capture_sched.sv
// Directed bench for preproc_capture_sched: framing, saturation, backpressure,
// abort/flush, config rejection, optional ramp source and mid-run reset.
module tb_preproc_capture_sched;

    localparam int ADC_WIDTH = 14;
    localparam int NUM_SRC   = 4;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [4:0]                   cfg_sel_src = '0;
    logic [15:0]                  cfg_offset = '0;
    logic [15:0]                  cfg_pkt_len = '0;
    logic [7:0]                   cfg_pkt_num = '0;
    logic                         cfg_start = 1'b0;
    logic                         cfg_abort = 1'b0;
    logic [NUM_SRC*ADC_WIDTH-1:0] src_data = '0;
    logic [NUM_SRC-1:0]           src_valid = '0;
    logic [ADC_WIDTH-1:0]         m_data;
    logic                         m_valid;
    logic                         m_last;
    logic                         m_ready = 1'b1;
    logic                         busy;
    logic                         done;
    logic                         err_cfg;
    logic                         err_overrun;
    logic [7:0]                   pkt_cnt;

    int total = 0;
    int bad   = 0;

    preproc_capture_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_sel_src (cfg_sel_src),
        .cfg_offset  (cfg_offset),
        .cfg_pkt_len (cfg_pkt_len),
        .cfg_pkt_num (cfg_pkt_num),
        .cfg_start   (cfg_start),
        .cfg_abort   (cfg_abort),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg),
        .err_overrun (err_overrun),
        .pkt_cnt     (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [ADC_WIDTH-1:0] val);
        src_data[idx*ADC_WIDTH +: ADC_WIDTH] = val;
        src_valid[idx] = 1'b1;
        step();
        src_valid = '0;
    endtask

    // Pulse start and walk through ARM; returns with the DUT in STREAM
    task automatic start_run(input logic [4:0] sel, input logic [15:0] off,
                             input logic [15:0] len, input logic [7:0] num);
        cfg_sel_src = sel;
        cfg_offset  = off;
        cfg_pkt_len = len;
        cfg_pkt_num = num;
        cfg_start   = 1'b1;
        step();
        cfg_start = 1'b0;
        check("arm_busy", 32'(busy), 32'd1);
        step();
    endtask

    initial begin
        // Reset state
        src_data = {14'd3000, 14'd2000, 14'd1000, 14'd500};
        #12;
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_cfg", 32'(err_cfg), 32'd0);
        check("rst_err_overrun", 32'(err_overrun), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst_n = 1'b1;

        // Two packets of four from source 1, paced every 3 cycles
        start_run(5'd1, 16'd0, 16'd4, 8'd2);
        for (int k = 0; k < 8; k++) begin
            send(1, 14'(k));
            check("r1_data", 32'(m_data), 32'(k));
            check("r1_valid", 32'(m_valid), 32'd1);
            check("r1_last", 32'(m_last), 32'((k % 4) == 3));
            step();
            check("r1_drain", 32'(m_valid), 32'd0);
            check("r1_pkt_cnt", 32'(pkt_cnt), 32'((k + 1) / 4));
            check("r1_done", 32'(done), 32'(k == 7));
            check("r1_busy", 32'(busy), 32'(k != 7));
            if (k != 7) step();
        end
        step();
        check("r1_done_pulse", 32'(done), 32'd0);

        // Positive saturation and an in-range negative result
        start_run(5'd0, 16'd100, 16'd1, 8'd2);
        send(0, 14'h1FD6);                      // 8150 + 100 -> 8191
        check("satp_data", 32'(m_data), 32'h1FFF);
        check("satp_last", 32'(m_last), 32'd1);
        step();
        check("satp_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("satp_busy", 32'(busy), 32'd1);
        send(0, 14'h3F38);                      // -200 + 100 -> -100
        check("satp_neg_data", 32'(m_data), 32'h3F9C);
        step();
        check("satp_done", 32'(done), 32'd1);
        check("satp_pkt_cnt2", 32'(pkt_cnt), 32'd2);

        // Negative saturation; offset change while busy must be ignored
        start_run(5'd2, 16'hFF9C, 16'd1, 8'd1);
        cfg_offset = 16'd0;
        send(2, 14'h202A);                      // -8150 - 100 -> -8192
        check("satn_data", 32'(m_data), 32'h2000);
        step();
        check("satn_done", 32'(done), 32'd1);

        // Backpressure: second strobe dropped, counter does not advance
        m_ready = 1'b0;
        start_run(5'd3, 16'd0, 16'd2, 8'd1);
        send(3, 14'd10);
        check("bp_first_data", 32'(m_data), 32'd10);
        check("bp_first_last", 32'(m_last), 32'd0);
        check("bp_no_overrun", 32'(err_overrun), 32'd0);
        step();
        send(3, 14'd20);
        check("bp_held_data", 32'(m_data), 32'd10);
        check("bp_held_valid", 32'(m_valid), 32'd1);
        check("bp_overrun", 32'(err_overrun), 32'd1);
        m_ready = 1'b1;
        step();
        check("bp_drain", 32'(m_valid), 32'd0);
        send(3, 14'd30);
        check("bp_last_data", 32'(m_data), 32'd30);
        check("bp_last_flag", 32'(m_last), 32'd1);
        step();
        check("bp_done", 32'(done), 32'd1);
        check("bp_busy", 32'(busy), 32'd0);
        check("bp_sticky", 32'(err_overrun), 32'd1);

        // Abort with a pending beat: forced last, FLUSH, no done
        m_ready = 1'b0;
        start_run(5'd1, 16'd0, 16'd4, 8'd0);
        check("ab_overrun_clr", 32'(err_overrun), 32'd0);
        send(1, 14'd55);
        check("ab_pend_last", 32'(m_last), 32'd0);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        check("ab_forced_last", 32'(m_last), 32'd1);
        check("ab_flush_busy", 32'(busy), 32'd1);
        check("ab_flush_data", 32'(m_data), 32'd55);
        send(1, 14'd77);
        check("ab_no_accept", 32'(m_data), 32'd55);
        m_ready = 1'b1;
        step();
        check("ab_idle", 32'(busy), 32'd0);
        check("ab_valid", 32'(m_valid), 32'd0);
        check("ab_no_done", 32'(done), 32'd0);

        // Abort with nothing pending returns to IDLE at once
        start_run(5'd0, 16'd0, 16'd4, 8'd0);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        check("ab2_idle", 32'(busy), 32'd0);
        check("ab2_no_done", 32'(done), 32'd0);

        // Rejected starts
        cfg_sel_src = 5'd5;
        cfg_pkt_len = 16'd4;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("ec_sel_err", 32'(err_cfg), 32'd1);
        check("ec_sel_busy", 32'(busy), 32'd0);
        step();
        check("ec_pulse", 32'(err_cfg), 32'd0);
        cfg_sel_src = 5'd0;
        cfg_pkt_len = 16'd0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("ec_len_err", 32'(err_cfg), 32'd1);
        check("ec_len_busy", 32'(busy), 32'd0);
        step();

`ifdef PREPROC_RAMP_SRC_EN
        // Ramp source: beats 0,1,2 three cycles apart, then done
        start_run(5'd4, 16'd0, 16'd3, 8'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            step();
            step();
            check("ramp_data", 32'(m_data), 32'(k));
            check("ramp_valid", 32'(m_valid), 32'd1);
            check("ramp_last", 32'(m_last), 32'(k == 2));
        end
        step();
        check("ramp_done", 32'(done), 32'd1);
`else
        cfg_sel_src = 5'd4;
        cfg_pkt_len = 16'd3;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("ec_ramp_err", 32'(err_cfg), 32'd1);
        check("ec_ramp_busy", 32'(busy), 32'd0);
`endif

        // Asynchronous reset mid-run clears the pending beat immediately
        start_run(5'd1, 16'd0, 16'd4, 8'd0);
        m_ready = 1'b0;
        send(1, 14'd9);
        check("mr_pend", 32'(m_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(m_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
